stopwatch_timer_ctrl: RTL and testbench

- Run-control sequencer for the 4-digit stopwatch/timer.
- Conditions the raw startstop/resetload buttons, decodes the 2-bit mode switches and loads presets from the 8 switches.
- Steps a 4-digit BCD count (MM.SS-style, 00.00..99.99) up or down on each count tick.
- Feeds the digits to the seven-segment mux; sits between the switch/button inputs and the display path.

---
 rtl/stopwatch_timer_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_stopwatch_timer_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer_ctrl.sv
// Run-control sequencer for the 4-digit BCD stopwatch/timer.
// Conditions the start/stop and reset/load buttons, decodes the mode switches,
// builds presets from the 8 switches and steps the BCD count on each tick.
module stopwatch_timer_ctrl #(
  parameter int DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  mode,
  input  logic        startstop,
  input  logic        resetload,
  input  logic [7:0]  switch,
  output logic [15:0] digits,
  output logic        running,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter saturates at DB_CYCLES so a held button never fires again.
  localparam int             CW       = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_FIRE = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DB_CYCLES);

  // Index 0 is startstop, index 1 is resetload.
  logic [1:0]    sync1, sync2;
  logic [CW-1:0] stable_cnt [2];
  logic [1:0]    raw_btn;
  logic [1:0]    press;

  state_t        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [1:0]    mode_q;

  logic          count_down;
  logic [15:0]   terminal;
  logic [15:0]   preset;
  logic [15:0]   stepped;

  assign raw_btn = {resetload, startstop};

  // Clamp a switch nibble into the BCD range.
  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Add one to a 4-digit BCD value with ripple carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Subtract one from a 4-digit BCD value with ripple borrow.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Two-flop synchronizers and stable-level counters for both buttons.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      for (int b = 0; b < 2; b++) stable_cnt[b] <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        if (!sync2[b])                    stable_cnt[b] <= '0;
        else if (stable_cnt[b] != CNT_MAX) stable_cnt[b] <= stable_cnt[b] + 1'b1;
      end
    end
  end

  // One-cycle press pulse when the level has been stable long enough.
  always_comb begin
    for (int b = 0; b < 2; b++) press[b] = sync2[b] && (stable_cnt[b] == CNT_FIRE);
  end

  // Direction, terminal value, preset and the next count value.
  always_comb begin
    count_down = mode[1];
    terminal   = count_down ? 16'h0000 : 16'h9999;
    case (mode)
      2'b00:   preset = 16'h0000;
      2'b10:   preset = 16'h9999;
      default: preset = {clamp9(switch[7:4]), clamp9(switch[3:0]), 8'h00};
    endcase
    stepped = count_down ? bcd_dec(digits_q) : bcd_inc(digits_q);
  end

  // Next-state and next-digit logic for the run-control FSM.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d  = state_q;
    digits_d = digits_q;
    if (mode != mode_q) begin
      state_d  = IDLE;
      digits_d = preset;
    end else begin
      case (state_q)
        IDLE: begin
          if (press[1]) begin
            digits_d = preset;
          end else if (press[0]) begin
            state_d = (digits_q == terminal) ? DONE : RUN;
          end
        end
        RUN: begin
          if (press[1]) begin
            state_d  = IDLE;
            digits_d = preset;
          end else if (press[0]) begin
            state_d = PAUSE;
          end else if (tick) begin
            digits_d = stepped;
            if (stepped == terminal) state_d = DONE;
          end
        end
        PAUSE: begin
          if (press[1]) begin
            state_d  = IDLE;
            digits_d = preset;
          end else if (press[0]) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (press[1]) begin
            state_d  = IDLE;
            digits_d = preset;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, digit and mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      digits_q <= 16'h0000;
      // Track the live mode through reset so release does not look like a mode change.
      mode_q   <= mode;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      mode_q   <= mode;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Directed self-checking bench for stopwatch_timer_ctrl with DB_CYCLES = 2.
module tb_stopwatch_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [1:0]  mode;
  logic        startstop;
  logic        resetload;
  logic [7:0]  switch;
  logic [15:0] digits;
  logic        running;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  stopwatch_timer_ctrl #(.DB_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .mode      (mode),
    .startstop (startstop),
    .resetload (resetload),
    .switch    (switch),
    .digits    (digits),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold the given buttons through the debounce window; FSM reacts on the 4th edge.
  task automatic press(input logic ss, input logic rl);
    startstop = ss;
    resetload = rl;
    step(4);
    startstop = 1'b0;
    resetload = 1'b0;
    step(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; mode = 2'b00;
    startstop = 1'b0; resetload = 1'b0; switch = 8'h00;
    step(2);
    reset = 1'b0;
    step();
    check("reset_digits",  digits,  16'h0000);
    check("reset_running", running, 1'b0);
    check("reset_done",    done,    1'b0);

    // Latency: raw high sampled at edge 0, state changes at edge 3.
    startstop = 1'b1;
    step(3);
    check("pre_latency_running", running, 1'b0);
    step();
    check("latency_running", running, 1'b1);
    startstop = 1'b0;
    step(3);
    ticks(3);
    check("up_3_ticks", digits, 16'h0003);
    press(1'b1, 1'b0);
    check("pause_running", running, 1'b0);
    ticks(2);
    check("pause_hold", digits, 16'h0003);

    // One-cycle glitch must not register.
    startstop = 1'b1;
    step();
    startstop = 1'b0;
    step(5);
    check("glitch_ignored", running, 1'b0);

    // Held for 20 cycles: exactly one toggle PAUSE -> RUN.
    startstop = 1'b1;
    step(20);
    startstop = 1'b0;
    step(3);
    check("held_one_toggle", running, 1'b1);
    ticks(1);
    check("resume_count", digits, 16'h0004);

    // Both buttons together in RUN: reset/load wins.
    press(1'b1, 1'b1);
    check("both_running", running, 1'b0);
    check("both_digits",  digits,  16'h0000);
    ticks(2);
    check("idle_tick_ignored", digits, 16'h0000);

    // Mode change 00 -> 10 during RUN.
    press(1'b1, 1'b0);
    ticks(1);
    check("run_again", digits, 16'h0001);
    mode = 2'b10;
    step();
    check("mode_chg_digits",  digits,  16'h9999);
    check("mode_chg_running", running, 1'b0);

    // Mode 01 from preset 99 up to the terminal value.
    switch = 8'h99;
    mode   = 2'b01;
    step();
    check("mode01_preset", digits, 16'h9900);
    press(1'b1, 1'b0);
    ticks(98);
    check("up_to_9998", digits, 16'h9998);
    check("up_9998_done", done, 1'b0);
    ticks(1);
    check("up_9999", digits, 16'h9999);
    check("up_done", done, 1'b1);
    check("up_done_running", running, 1'b0);
    ticks(1);
    check("done_hold", digits, 16'h9999);
    press(1'b0, 1'b1);
    check("reload_digits", digits, 16'h9900);
    check("reload_done",   done,   1'b0);

    // Clamp of out-of-range nibbles; switch only applies on load.
    switch = 8'hFA;
    step(2);
    check("switch_no_load", digits, 16'h9900);
    press(1'b0, 1'b1);
    check("clamp_FA", digits, 16'h9900);
    switch = 8'h3C;
    press(1'b0, 1'b1);
    check("clamp_3C", digits, 16'h3900);

    // Timer from preset, mode 11.
    switch = 8'h88;
    mode   = 2'b11;
    step();
    check("mode11_preset", digits, 16'h8800);
    press(1'b1, 1'b0);
    ticks(1);
    check("down_borrow", digits, 16'h8799);
    switch = 8'h01;
    press(1'b0, 1'b1);
    check("preset_0100", digits, 16'h0100);
    check("preset_idle", running, 1'b0);
    press(1'b1, 1'b0);
    ticks(99);
    check("down_0001", digits, 16'h0001);
    ticks(1);
    check("down_0000", digits, 16'h0000);
    check("down_done", done, 1'b1);
    press(1'b1, 1'b0);
    check("done_ss_ignored", done, 1'b1);
    check("done_ss_digits",  digits, 16'h0000);

    // Start in IDLE with digits already at terminal goes straight to DONE.
    switch = 8'h00;
    press(1'b0, 1'b1);
    check("zero_preset_idle", done, 1'b0);
    press(1'b1, 1'b0);
    check("idle_to_done", done, 1'b1);
    check("idle_to_done_running", running, 1'b0);

    // Synchronous reset during RUN.
    mode = 2'b00;
    step();
    press(1'b1, 1'b0);
    ticks(5);
    check("pre_reset_count", digits, 16'h0005);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_run_digits",  digits,  16'h0000);
    check("reset_run_running", running, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
